// File: rtl/hsv2rgb_pipe_pkg.sv
// Shared ISP colour definitions: hue geometry helpers, sector and mode encodings, sync bundle.
// Pure declarations: no timing and no flow control of its own.
package hsv2rgb_pipe_pkg;

  typedef enum logic [2:0] {
    SEC_0 = 3'd0,
    SEC_1 = 3'd1,
    SEC_2 = 3'd2,
    SEC_3 = 3'd3,
    SEC_4 = 3'd4,
    SEC_5 = 3'd5
  } sector_e;

  typedef enum logic {
    MODE_CONV = 1'b0,
    MODE_GRAY = 1'b1
  } mode_e;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

  localparam int SYNC_W = $bits(sync_t);

  function automatic int sector_size(input int hue_max);
    return hue_max / 6;
  endfunction

  function automatic int hue_width(input int hue_max);
    return $clog2(hue_max);
  endfunction

  // Width of the in-sector fraction; never below one bit.
  function automatic int frac_width(input int sector);
    return (sector > 1) ? $clog2(sector) : 1;
  endfunction

endpackage

// File: rtl/hsv2rgb_pipe_sync_delay.sv
// Reset-clearable shift register of DEPTH stages, W bits wide, for video sync bundles.
// Latency DEPTH cycles; advances every cycle, no backpressure.
module hsv2rgb_pipe_sync_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/hsv2rgb_pipe.sv
// Exact integer HSV-to-RGB converter with per-frame hue rotation / gray mode and sticky range flag.
// Latency 6 cycles for data and sync; free-running pipeline, no backpressure.
module hsv2rgb_pipe
  import hsv2rgb_pipe_pkg::*;
#(
  parameter  int DW      = 8,
  parameter  int HUE_MAX = 360,
  localparam int SECTOR  = sector_size(HUE_MAX),
  localparam int HW      = hue_width(HUE_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_vs,
  input  logic          i_hs,
  input  logic          i_de,
  input  logic [HW-1:0] i_hsv_h,
  input  logic [DW-1:0] i_hsv_s,
  input  logic [DW-1:0] i_hsv_v,
  input  logic          i_mode,
  input  logic [HW-1:0] i_hue_offset,
  output logic          rgb_vs,
  output logic          rgb_hs,
  output logic          rgb_de,
  output logic [DW-1:0] rgb_r,
  output logic [DW-1:0] rgb_g,
  output logic [DW-1:0] rgb_b,
  output logic          o_range_err
);

  localparam int FW  = frac_width(SECTOR);
  localparam int PW  = 2 * DW;
  localparam int DFW = DW + FW;

  localparam logic [HW-1:0]  HUE_MAX_N = HW'(HUE_MAX);
  localparam logic [HW-1:0]  HUE_LAST  = HW'(HUE_MAX - 1);
  localparam logic [HW:0]    HUE_MAX_X = (HW+1)'(HUE_MAX);
  localparam logic [HW-1:0]  SECTOR_N  = HW'(SECTOR);
  localparam logic [PW-1:0]  FS_N      = PW'((2 ** DW) - 1);
  localparam logic [DFW-1:0] SECTOR_D  = DFW'(SECTOR);

  // Frame-level shadow config; a vs rise takes effect on the pixel sampled with it.
  logic          vs_prev, vs_rise, h_oob;
  mode_e         shadow_mode, cur_mode;
  logic [HW-1:0] shadow_off, off_clean, cur_off, hue_clamp, hue_rot;
  logic [HW:0]   hue_sum;

  assign vs_rise   = i_vs & ~vs_prev;
  assign off_clean = (i_hue_offset >= HUE_MAX_N) ? '0 : i_hue_offset;
  assign cur_mode  = vs_rise ? mode_e'(i_mode) : shadow_mode;
  assign cur_off   = vs_rise ? off_clean : shadow_off;
  assign h_oob     = i_hsv_h >= HUE_MAX_N;
  assign hue_clamp = h_oob ? HUE_LAST : i_hsv_h;
  assign hue_sum   = {1'b0, hue_clamp} + {1'b0, cur_off};
  assign hue_rot   = (hue_sum >= HUE_MAX_X) ? HW'(hue_sum - HUE_MAX_X) : HW'(hue_sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev     <= 1'b0;
      shadow_mode <= MODE_CONV;
      shadow_off  <= '0;
      o_range_err <= 1'b0;
    end else begin
      vs_prev <= i_vs;
      if (vs_rise) begin
        shadow_mode <= mode_e'(i_mode);
        shadow_off  <= off_clean;
      end
      if (i_de && h_oob) o_range_err <= 1'b1;
      else if (vs_rise)  o_range_err <= 1'b0;
    end
  end

  // Sync travels five stages here; the sixth is the output register below.
  sync_t sync_in, sync_d5;
  assign sync_in = '{vs: i_vs, hs: i_hs, de: i_de};

  hsv2rgb_pipe_sync_delay #(
    .W     (SYNC_W),
    .DEPTH (5)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .din   (sync_in),
    .dout  (sync_d5)
  );

  logic [HW-1:0]  s1_hue;
  logic [DW-1:0]  s1_v;
  logic [PW-1:0]  s1_prod;
  mode_e          s1_mode;
  sector_e        s2_sec, s3_sec, s4_sec;
  logic [FW-1:0]  s2_f;
  logic [DW-1:0]  s2_v, s2_p, s3_v, s3_p, s4_v, s4_p, s4_t;
  mode_e          s2_mode, s3_mode, s4_mode;
  logic [DFW-1:0] s3_df;
  logic [DW-1:0]  s5_r, s5_g, s5_b;

  sector_e        s2_sec_n;
  logic [FW-1:0]  s2_f_n;
  logic [DW-1:0]  s2_p_n, s3_d, s4_t_n;
  logic [DFW-1:0] s3_df_n;

  assign s2_sec_n = sector_e'(3'(s1_hue / SECTOR_N));
  assign s2_f_n   = FW'(s1_hue % SECTOR_N);
  assign s2_p_n   = s1_v - DW'(s1_prod / FS_N);
  assign s3_d     = s2_v - s2_p;
  assign s3_df_n  = DFW'(s3_d) * DFW'(s2_f);
  assign s4_t_n   = DW'(s3_df / SECTOR_D);

  logic [DW-1:0] sel_r, sel_g, sel_b, p_plus_t, v_minus_t;

  assign p_plus_t  = s4_p + s4_t;
  assign v_minus_t = s4_v - s4_t;

  always_comb begin
    sel_r = s4_v;
    sel_g = s4_v;
    sel_b = s4_v;
    if (s4_mode == MODE_CONV) begin
      case (s4_sec)
        SEC_0:   begin sel_r = s4_v;      sel_g = p_plus_t;  sel_b = s4_p;      end
        SEC_1:   begin sel_r = v_minus_t; sel_g = s4_v;      sel_b = s4_p;      end
        SEC_2:   begin sel_r = s4_p;      sel_g = s4_v;      sel_b = p_plus_t;  end
        SEC_3:   begin sel_r = s4_p;      sel_g = v_minus_t; sel_b = s4_v;      end
        SEC_4:   begin sel_r = p_plus_t;  sel_g = s4_p;      sel_b = s4_v;      end
        SEC_5:   begin sel_r = s4_v;      sel_g = s4_p;      sel_b = v_minus_t; end
        default: begin sel_r = s4_v;      sel_g = s4_v;      sel_b = s4_v;      end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_hue  <= '0;  s1_v  <= '0;  s1_prod <= '0;  s1_mode <= MODE_CONV;
      s2_sec  <= SEC_0; s2_f <= '0; s2_v <= '0; s2_p <= '0; s2_mode <= MODE_CONV;
      s3_sec  <= SEC_0; s3_df <= '0; s3_v <= '0; s3_p <= '0; s3_mode <= MODE_CONV;
      s4_sec  <= SEC_0; s4_t <= '0; s4_v <= '0; s4_p <= '0; s4_mode <= MODE_CONV;
      s5_r    <= '0;  s5_g  <= '0;  s5_b    <= '0;
      rgb_vs  <= 1'b0; rgb_hs <= 1'b0; rgb_de <= 1'b0;
      rgb_r   <= '0;  rgb_g <= '0;  rgb_b   <= '0;
    end else begin
      s1_hue  <= hue_rot;
      s1_v    <= i_hsv_v;
      s1_prod <= PW'(i_hsv_v) * PW'(i_hsv_s);
      s1_mode <= cur_mode;

      s2_sec  <= s2_sec_n;
      s2_f    <= s2_f_n;
      s2_v    <= s1_v;
      s2_p    <= s2_p_n;
      s2_mode <= s1_mode;

      s3_sec  <= s2_sec;
      s3_df   <= s3_df_n;
      s3_v    <= s2_v;
      s3_p    <= s2_p;
      s3_mode <= s2_mode;

      s4_sec  <= s3_sec;
      s4_t    <= s4_t_n;
      s4_v    <= s3_v;
      s4_p    <= s3_p;
      s4_mode <= s3_mode;

      s5_r <= sel_r;
      s5_g <= sel_g;
      s5_b <= sel_b;

      // Blank colour outside the active window.
      rgb_vs <= sync_d5.vs;
      rgb_hs <= sync_d5.hs;
      rgb_de <= sync_d5.de;
      rgb_r  <= sync_d5.de ? s5_r : '0;
      rgb_g  <= sync_d5.de ? s5_g : '0;
      rgb_b  <= sync_d5.de ? s5_b : '0;
    end
  end

endmodule

// File: doc/hsv2rgb_pipe.md
Name: hsv2rgb_pipe

Overview:
Parametrised, fully pipelined HSV-to-RGB converter for the ISP video path. It is the next generation of the fixed 8-bit converter.
- Generalised in channel width and hue range.
- Exact integer arithmetic.
- Hue rotation and a gray mode, both latched per frame.
- A sticky out-of-range flag.
- It sits between the HSV processing stages and the RGB output formatter. Video sync signals travel alongside the data.

Parameters:
DW, 8, channel width of S, V and of the R/G/B outputs; full scale is 2^DW-1.
HUE_MAX, 360, number of hue codes; must be divisible by 6. Derived: SECTOR=HUE_MAX/6, HW=clog2(HUE_MAX).

Ports:
clk  in  1  pixel clock; single clock domain.
reset  in  1  asynchronous, active-high reset.
i_vs  in  1  vertical sync.
i_hs  in  1  horizontal sync.
i_de  in  1  data enable.
i_hsv_h  in  HW  hue, valid range 0..HUE_MAX-1.
i_hsv_s  in  DW  saturation.
i_hsv_v  in  DW  value.
i_mode  in  1  0 = colour conversion, 1 = gray (R=G=B=V); latched per frame.
i_hue_offset  in  HW  hue rotation; latched per frame.
rgb_vs  out  1  vertical sync, delayed 6 cycles.
rgb_hs  out  1  horizontal sync, delayed 6 cycles.
rgb_de  out  1  data enable, delayed 6 cycles.
rgb_r  out  DW  red.
rgb_g  out  DW  green.
rgb_b  out  DW  blue.
o_range_err  out  1  sticky flag: an active pixel had h >= HUE_MAX in the current frame.

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-high.
- While reset is high, every output and every internal register is 0, including shadow config and o_range_err. This applies at any point, including mid-frame.

Latency and sync:
- Fixed latency of 6 cycles. Inputs sampled at edge N appear on outputs after edge N+6.
- vs/hs/de and all data follow the same 6-stage delay.
- Pipeline registers advance every cycle; they are not gated by de.
- Blanking: rgb_r/g/b = 0 whenever rgb_de = 0.

Per-frame shadow config:
- A rising edge of i_vs (i_vs=1, previous i_vs=0) loads i_mode and i_hue_offset into shadow registers.
- The new values apply to pixels sampled on that same cycle and after.
- Mid-frame changes to i_mode or i_hue_offset have no effect until the next vs rise.
- An offset >= HUE_MAX is loaded as 0.

Hue preparation, stage 1:
- hc = min(h, HUE_MAX-1).
- hr = hc + offset; if hr >= HUE_MAX then hr -= HUE_MAX.

Arithmetic (exact, no approximation error allowed; FS = 2^DW-1):
- sector i = floor(hr/SECTOR), range 0..5.
- f = hr mod SECTOR.
- p = v - floor(v*s/FS).
- d = v - p.
- t = floor(d*f/SECTOR).
- Implementation may use reciprocal multiplies, provided the result is bit-exact over all inputs.

Output selection by sector:
- 0: R=v, G=p+t, B=p
- 1: R=v-t, G=v, B=p
- 2: R=p, G=v, B=p+t
- 3: R=p, G=v-t, B=v
- 4: R=p+t, G=p, B=v
- 5: R=v, G=p, B=v-t
- Results never overflow DW because t <= d.
- s = 0 gives R=G=B=v naturally; no special case is needed.
- Gray mode forces R=G=B=v through the same 6-cycle latency.

Stage allocation:
- S1: register inputs, hue clamp and rotate, start v*s.
- S2: sector/f, p.
- S3: d*f.
- S4: t.
- S5: select.
- S6: output register and blank.

o_range_err:
- Set on input-side sampling of a pixel with i_de=1 and i_hsv_h >= HUE_MAX.
- Cleared on an i_vs rising edge.
- If set and clear occur in the same cycle, set wins.
- Not delayed by the pipeline.

Decomposition:
- Shared ISP colour header/package: SECTOR and HW derivations, sector encoding constants 0..5, mode encodings (MODE_CONV=0, MODE_GRAY=1).
- One sub-module, sync_delay: a parametrised-width, parametrised-depth shift register used for vs/hs/de. It is reusable by other ISP blocks.

Test Plan (DW=8, HUE_MAX=360, mode 0, offset 0 unless stated):
1. h=0, s=255, v=255 with de=1 -> six cycles later rgb_de=1 and RGB=(255,0,0). Sync outputs match inputs delayed 6.
2. h=90, s=255, v=200 -> (100,200,0). h=240, s=128, v=100 -> (50,50,100).
3. s=0, v=77, h swept 0..359 -> always (77,77,77). Gray mode with h=90, s=255, v=200 -> (200,200,200).
4. Offset 120 driven mid-frame: no effect until the next vs rise. After the rise, h=300, s=255, v=255 -> (255,255,0).
5. h=400, s=255, v=255, de=1 -> clamped to 359, RGB=(255,0,5). o_range_err=1 until the next vs rise, then 0. The same h with de=0 does not set the flag.
6. Assert reset for 1 cycle mid-frame -> all outputs 0 immediately, shadow config returns to mode 0 / offset 0. The first valid output appears 6 cycles after the first de following reset release.
